// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD scanner: column drive, row debounce, key queue with sticky overflow.
// Define KYPD_FIFO_EN for a 4-entry key FIFO; otherwise a single holding register is used.
module kypd_scan_ctrl #(
  parameter int PRESCALE_BITS  = 20,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overflow,
  input  logic       ovf_clr
);

`ifdef KYPD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [3:0] DB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PUSH, HELD} state_t;

  logic [3:0]               row_meta, row_sync;
  logic [PRESCALE_BITS-1:0] presc;
  logic                     tick;

  state_t     state, state_nx;
  logic [1:0] col, col_nx;
  logic [1:0] cap_row, cap_row_nx;
  logic [1:0] cap_col, cap_col_nx;
  logic [3:0] match_cnt, match_nx;
  logic [3:0] rel_cnt, rel_nx;
  logic       push, clear_down;
  logic       any_low;
  logic [1:0] low_row;
  logic [3:0] push_code;

  logic [3:0]       q_data [DEPTH];
  logic [3:0]       d_nx   [DEPTH];
  logic [DEPTH-1:0] q_vld, v_nx;
  logic [2:0]       q_cnt, cnt_nx;
  logic             pop, full, ovf_set;

  // Rows come straight from the keypad pins and are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      tick  <= (presc == '1);
    end
  end

  assign any_low = ~&row_sync;

  always_comb begin
    low_row = 2'd3;
    if (!row_sync[2]) low_row = 2'd2;
    if (!row_sync[1]) low_row = 2'd1;
    if (!row_sync[0]) low_row = 2'd0;
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign push_code = key_map(cap_row, cap_col);
  assign col_n     = ~(4'b0001 << col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      cap_row   <= 2'd0;
      cap_col   <= 2'd0;
      match_cnt <= 4'd0;
      rel_cnt   <= 4'd0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      cap_row   <= cap_row_nx;
      cap_col   <= cap_col_nx;
      match_cnt <= match_nx;
      rel_cnt   <= rel_nx;
      if (push)            key_down <= 1'b1;
      else if (clear_down) key_down <= 1'b0;
    end
  end

  // The column stays parked on the captured key through DEBOUNCE and HELD,
  // so a second key on another column cannot disturb a held press.
  always_comb begin
    state_nx   = state;
    col_nx     = col;
    cap_row_nx = cap_row;
    cap_col_nx = cap_col;
    match_nx   = match_cnt;
    rel_nx     = rel_cnt;
    push       = 1'b0;
    clear_down = 1'b0;
    unique case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cap_row_nx = low_row;
            cap_col_nx = col;
            match_nx   = 4'd0;
            state_nx   = DEBOUNCE;
          end else begin
            col_nx = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!row_sync[cap_row]) begin
            match_nx = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == DB_N) state_nx = PUSH;
          end else begin
            state_nx = SCAN;
            col_nx   = col + 2'd1;
          end
        end
      end
      PUSH: begin
        push     = 1'b1;
        rel_nx   = 4'd0;
        state_nx = HELD;
      end
      HELD: begin
        if (tick) begin
          if (&row_sync) begin
            rel_nx = rel_cnt + 4'd1;
            if (rel_cnt + 4'd1 == DB_N) begin
              clear_down = 1'b1;
              state_nx   = SCAN;
              col_nx     = col + 2'd1;
            end
          end else begin
            rel_nx = 4'd0;
          end
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  assign pop  = q_vld[0] & key_ack;
  assign full = (q_cnt == DEPTH_C);

  // Shift queue: entry 0 is always the head, so key_code/key_valid are flop outputs.
  // A pop frees a slot in the same cycle, letting a push into a full queue land.
  always_comb begin
    d_nx    = q_data;
    v_nx    = q_vld;
    cnt_nx  = q_cnt;
    ovf_set = 1'b0;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        d_nx[i] = q_data[i+1];
        v_nx[i] = q_vld[i+1];
      end
      v_nx[DEPTH-1] = 1'b0;
      cnt_nx        = q_cnt - 3'd1;
    end
    if (push) begin
      if (full && !pop) begin
        ovf_set = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (3'(i) == cnt_nx) begin
            d_nx[i] = push_code;
            v_nx[i] = 1'b1;
          end
        end
        cnt_nx = cnt_nx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_data[i] <= 4'h0;
      q_vld    <= '0;
      q_cnt    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      q_data <= d_nx;
      q_vld  <= v_nx;
      q_cnt  <= cnt_nx;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign key_code  = q_data[0];
  assign key_valid = q_vld[0];

endmodule
